// File: rtl/music_tools_pkg.sv
// Shared constants for the music_tools audio path: mode codes, the
// controller state encoding and the controller's default timing.
package music_tools_pkg;

    localparam logic [1:0] MODE_TONE  = 2'b00;
    localparam logic [1:0] MODE_METRO = 2'b01;
    localparam logic [1:0] MODE_TUNER = 2'b10;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_MUTE  = 2'b10
    } ctrl_state_t;

    localparam int DEF_MUTE_SAMPLES = 16;
    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_MUTE_TIMEOUT = 65535;

endpackage

// File: rtl/mode_request_decoder.sv
// Priority decode of the active-low mode keys; the lowest-index pressed key
// wins and no pressed key means no request.
module mode_request_decoder
    import music_tools_pkg::*;
(
    input  logic [2:0] key_n,
    output logic       req_valid,
    output logic [1:0] req_mode
);

    always_comb begin
        req_valid = 1'b1;
        req_mode  = MODE_TONE;
        if (!key_n[0])      req_mode  = MODE_TONE;
        else if (!key_n[1]) req_mode  = MODE_METRO;
        else if (!key_n[2]) req_mode  = MODE_TUNER;
        else                req_valid = 1'b0;
    end

endmodule

// File: rtl/audio_mode_controller.sv
// Owns the shared codec path: muxes tone/metronome samples and runs a
// mute -> reset -> resume sequence on every mode key or switch change.
module audio_mode_controller
    import music_tools_pkg::*;
#(
    parameter int MUTE_SAMPLES = DEF_MUTE_SAMPLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MUTE_TIMEOUT = DEF_MUTE_TIMEOUT
)(
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [2:0]  key_n,
    input  logic [9:0]  sw,
    input  logic        audio_out_allowed,
    input  logic        tg_write,
    input  logic [31:0] tg_sound,
    input  logic        mt_write,
    input  logic [31:0] mt_sound,
    output logic        write_audio_out,
    output logic [31:0] sound,
    output logic [1:0]  mode,
    output logic        core_reset,
    output logic        clear_audio_in,
    output logic        redraw,
    output logic        busy,
    output ctrl_state_t fsm_state
);

    // Handshake: write_audio_out offers a sample and the codec takes it only
    // in a cycle where audio_out_allowed is also high; both high = one sample.
    localparam int MW = $clog2(MUTE_SAMPLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [MW-1:0] MUTE_LIMIT = MW'(MUTE_SAMPLES);
    localparam logic [RW-1:0] RST_LIMIT  = RW'(RESET_CYCLES);
    localparam logic [15:0]   TO_LIMIT   = 16'(MUTE_TIMEOUT);

    ctrl_state_t   state;
    logic [1:0]    pend_mode;
    logic [9:0]    sw_q;
    logic          retrig;
    logic [MW-1:0] mute_cnt, mute_cnt_nx;
    logic [15:0]   to_cnt, to_cnt_nx;
    logic [RW-1:0] rst_cnt, rst_cnt_nx;
    logic          req_valid;
    logic [1:0]    req_mode;
    logic          mode_event, sw_event, any_event, mute_done;

    mode_request_decoder u_decoder (
        .key_n     (key_n),
        .req_valid (req_valid),
        .req_mode  (req_mode)
    );

    assign mode_event = req_valid && (req_mode != pend_mode);
    assign sw_event   = (sw != sw_q);
    assign any_event  = mode_event || sw_event;

    // Saturating next values; limits are tested on the next value so the
    // edge that completes the last sample or cycle is the exit edge.
    always_comb begin
        mute_cnt_nx = mute_cnt;
        if (audio_out_allowed && (mute_cnt != MUTE_LIMIT))
            mute_cnt_nx = mute_cnt + MW'(1);
        to_cnt_nx  = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
        rst_cnt_nx = (rst_cnt == RST_LIMIT) ? rst_cnt : rst_cnt + RW'(1);
    end

    assign mute_done = (mute_cnt_nx == MUTE_LIMIT) || (to_cnt_nx == TO_LIMIT);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= ST_RESET;
            mode       <= MODE_TONE;
            pend_mode  <= MODE_TONE;
            sw_q       <= sw;
            retrig     <= 1'b0;
            rst_cnt    <= '0;
            mute_cnt   <= '0;
            to_cnt     <= '0;
            redraw     <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
        end else begin
            sw_q       <= sw;
            redraw     <= 1'b0;
            core_reset <= !sw[9] || (state == ST_RESET);
            busy       <= (state != ST_RUN);
            if (mode_event)
                pend_mode <= req_mode;
            case (state)
                ST_RUN: begin
                    if (any_event) begin
                        state    <= ST_MUTE;
                        mute_cnt <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_MUTE: begin
                    mute_cnt <= mute_cnt_nx;
                    to_cnt   <= to_cnt_nx;
                    if (mute_done) begin
                        state      <= ST_RESET;
                        // A key arriving on the exit edge is folded into this reset.
                        mode       <= mode_event ? req_mode : pend_mode;
                        rst_cnt    <= '0;
                        core_reset <= 1'b1;
                    end
                end
                ST_RESET: begin
                    rst_cnt <= rst_cnt_nx;
                    if (rst_cnt_nx == RST_LIMIT) begin
                        redraw     <= 1'b1;
                        retrig     <= 1'b0;
                        core_reset <= !sw[9];
                        if (retrig || any_event) begin
                            state    <= ST_MUTE;
                            mute_cnt <= '0;
                            to_cnt   <= '0;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                        end
                    end else if (any_event) begin
                        retrig <= 1'b1;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        write_audio_out = 1'b0;
        sound           = '0;
        case (state)
            ST_RUN: begin
                case (mode)
                    MODE_TONE: begin
                        write_audio_out = tg_write;
                        sound           = tg_sound;
                    end
                    MODE_METRO: begin
                        write_audio_out = mt_write;
                        sound           = mt_sound;
                    end
                    default: ;
                endcase
            end
            ST_MUTE: write_audio_out = audio_out_allowed;
            default: ;
        endcase
    end

    assign clear_audio_in = (mode != MODE_TUNER);
    assign fsm_state      = state;

endmodule

// File: tb/tb_audio_mode_controller.sv
// Directed bench for audio_mode_controller: reset release, mode switching,
// tuner gating, mute timeout, retrigger during reset and the enable switch.
module tb_audio_mode_controller;
    import music_tools_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  key_n = 3'b111;
    logic [9:0]  sw = 10'h200;
    logic        audio_out_allowed = 1'b0;
    logic        tg_write = 1'b0;
    logic [31:0] tg_sound = 32'h0;
    logic        mt_write = 1'b0;
    logic [31:0] mt_sound = 32'h0;
    logic        write_audio_out;
    logic [31:0] sound;
    logic [1:0]  mode;
    logic        core_reset;
    logic        clear_audio_in;
    logic        redraw;
    logic        busy;
    ctrl_state_t fsm_state;

    int total = 0;
    int bad   = 0;

    audio_mode_controller dut (
        .CLOCK_50          (CLOCK_50),
        .resetn            (resetn),
        .key_n             (key_n),
        .sw                (sw),
        .audio_out_allowed (audio_out_allowed),
        .tg_write          (tg_write),
        .tg_sound          (tg_sound),
        .mt_write          (mt_write),
        .mt_sound          (mt_sound),
        .write_audio_out   (write_audio_out),
        .sound             (sound),
        .mode              (mode),
        .core_reset        (core_reset),
        .clear_audio_in    (clear_audio_in),
        .redraw            (redraw),
        .busy              (busy),
        .fsm_state         (fsm_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    // Runs until the next redraw pulse, measuring the sequence on the way.
    task automatic run_seq(input int limit, input bit toggle, output int rst_hi,
                           output int wr_ok, output int nz, output int mute_cyc,
                           output bit done);
        rst_hi = 0; wr_ok = 0; nz = 0; mute_cyc = 0; done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            if (toggle) audio_out_allowed = ~audio_out_allowed;
            #1;
            if (fsm_state == ST_MUTE) begin
                mute_cyc++;
                if (write_audio_out && audio_out_allowed) wr_ok++;
                if (sound != 32'h0) nz++;
            end
            if (core_reset) rst_hi++;
            tick;
            if (redraw) done = 1'b1;
        end
    endtask

    task automatic test_reset;
        int rh, wr, nz, mc;
        bit dn;
        repeat (3) tick;
        total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%0b exp=1", core_reset); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        total++; if (clear_audio_in !== 1'b1) begin bad++; $display("FAIL rst_clear got=%0b exp=1", clear_audio_in); end
        total++; if (write_audio_out !== 1'b0 || sound !== 32'h0) begin bad++; $display("FAIL rst_audio got=%0b/%h exp=0/0", write_audio_out, sound); end
        total++; if (mode !== MODE_TONE || redraw !== 1'b0) begin bad++; $display("FAIL rst_mode got=%b/%0b exp=00/0", mode, redraw); end
        resetn = 1'b1;
        run_seq(20, 1'b0, rh, wr, nz, mc, dn);
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL rel_redraw got=%0b exp=1", dn); end
        total++; if (rh != 4) begin bad++; $display("FAIL rel_reset_len got=%0d exp=4", rh); end
        total++; if (core_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rel_run got=%0b/%0b exp=0/0", core_reset, busy); end
        total++; if (mode !== MODE_TONE || fsm_state !== ST_RUN) begin bad++; $display("FAIL rel_mode got=%b/%0d exp=00/RUN", mode, fsm_state); end
        tick;
        total++; if (redraw !== 1'b0) begin bad++; $display("FAIL rel_pulse got=%0b exp=0", redraw); end
    endtask

    task automatic test_tone_pass;
        tg_sound = 32'h1000_0000; tg_write = 1'b1;
        mt_sound = 32'hdead_beef; mt_write = 1'b0;
        #1;
        total++; if (sound !== 32'h1000_0000 || write_audio_out !== 1'b1) begin bad++; $display("FAIL tone_pass got=%h/%0b exp=10000000/1", sound, write_audio_out); end
        tg_write = 1'b0;
        #1;
        total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL tone_idle got=%0b exp=0", write_audio_out); end
        tg_write = 1'b1;
    endtask

    task automatic test_metronome;
        int rh, wr, nz, mc;
        bit dn;
        key_n = 3'b101;
        tick;
        #1;
        total++; if (fsm_state !== ST_MUTE || busy !== 1'b1) begin bad++; $display("FAIL met_enter got=%0d/%0b exp=MUTE/1", fsm_state, busy); end
        total++; if (sound !== 32'h0) begin bad++; $display("FAIL met_gated got=%h exp=0", sound); end
        run_seq(200, 1'b1, rh, wr, nz, mc, dn);
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL met_done got=%0b exp=1", dn); end
        total++; if (wr != 16) begin bad++; $display("FAIL met_writes got=%0d exp=16", wr); end
        total++; if (nz != 0) begin bad++; $display("FAIL met_zero got=%0d exp=0", nz); end
        total++; if (rh != 4) begin bad++; $display("FAIL met_reset_len got=%0d exp=4", rh); end
        total++; if (mode !== MODE_METRO || fsm_state !== ST_RUN) begin bad++; $display("FAIL met_mode got=%b/%0d exp=01/RUN", mode, fsm_state); end
        mt_write = 1'b1;
        #1;
        total++; if (sound !== 32'hdead_beef || write_audio_out !== 1'b1) begin bad++; $display("FAIL met_pass got=%h/%0b exp=deadbeef/1", sound, write_audio_out); end
    endtask

    task automatic test_tuner;
        int rh, wr, nz, mc;
        bit dn;
        key_n = 3'b011;
        tick;
        run_seq(200, 1'b1, rh, wr, nz, mc, dn);
        key_n = 3'b111;
        total++; if (dn !== 1'b1 || rh != 4) begin bad++; $display("FAIL tun_seq got=%0b/%0d exp=1/4", dn, rh); end
        total++; if (mode !== MODE_TUNER || clear_audio_in !== 1'b0) begin bad++; $display("FAIL tun_mode got=%b/%0b exp=10/0", mode, clear_audio_in); end
        tg_write = 1'b1; mt_write = 1'b1;
        #1;
        total++; if (write_audio_out !== 1'b0 || sound !== 32'h0) begin bad++; $display("FAIL tun_silent got=%0b/%h exp=0/0", write_audio_out, sound); end
    endtask

    task automatic test_timeout;
        int rh, wr, nz, mc;
        bit dn;
        audio_out_allowed = 1'b0;
        sw = 10'h208;
        tick;
        run_seq(70000, 1'b0, rh, wr, nz, mc, dn);
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL to_done got=%0b exp=1", dn); end
        total++; if (mc != 65535) begin bad++; $display("FAIL to_mute_len got=%0d exp=65535", mc); end
        total++; if (rh != 4 || wr != 0) begin bad++; $display("FAIL to_reset got=%0d/%0d exp=4/0", rh, wr); end
        total++; if (mode !== MODE_TUNER || fsm_state !== ST_RUN) begin bad++; $display("FAIL to_mode got=%b/%0d exp=10/RUN", mode, fsm_state); end
    endtask

    task automatic test_retrig;
        int rh, wr, nz, mc, pulses;
        bit dn;
        sw = 10'h200;
        tick;
        for (int i = 0; i < 200 && fsm_state != ST_RESET; i++) begin
            audio_out_allowed = ~audio_out_allowed;
            tick;
        end
        total++; if (fsm_state !== ST_RESET) begin bad++; $display("FAIL rt_in_reset got=%0d exp=RESET", fsm_state); end
        key_n = 3'b101;
        run_seq(20, 1'b1, rh, wr, nz, mc, dn);
        pulses = dn ? 1 : 0;
        total++; if (rh != 4 || fsm_state !== ST_MUTE) begin bad++; $display("FAIL rt_remute got=%0d/%0d exp=4/MUTE", rh, fsm_state); end
        total++; if (mode !== MODE_TUNER || busy !== 1'b1) begin bad++; $display("FAIL rt_mid_mode got=%b/%0b exp=10/1", mode, busy); end
        run_seq(200, 1'b1, rh, wr, nz, mc, dn);
        if (dn) pulses++;
        total++; if (wr != 16 || rh != 4) begin bad++; $display("FAIL rt_second got=%0d/%0d exp=16/4", wr, rh); end
        repeat (3) begin
            tick;
            if (redraw) pulses++;
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL rt_redraws got=%0d exp=2", pulses); end
        total++; if (mode !== MODE_METRO || fsm_state !== ST_RUN) begin bad++; $display("FAIL rt_mode got=%b/%0d exp=01/RUN", mode, fsm_state); end
    endtask

    task automatic test_enable_switch;
        int rh, wr, nz, mc, low;
        bit dn;
        sw = 10'h000;
        tick;
        total++; if (core_reset !== 1'b1 || fsm_state !== ST_MUTE) begin bad++; $display("FAIL en_enter got=%0b/%0d exp=1/MUTE", core_reset, fsm_state); end
        run_seq(200, 1'b1, rh, wr, nz, mc, dn);
        total++; if (dn !== 1'b1 || rh != mc + 4) begin bad++; $display("FAIL en_forced got=%0d exp=%0d", rh, mc + 4); end
        low = 0;
        repeat (5) begin
            tick;
            if (!core_reset) low++;
        end
        total++; if (low != 0) begin bad++; $display("FAIL en_hold got=%0d exp=0", low); end
        sw = 10'h200;
        tick;
        total++; if (core_reset !== 1'b0 || fsm_state !== ST_MUTE) begin bad++; $display("FAIL en_back got=%0b/%0d exp=0/MUTE", core_reset, fsm_state); end
        run_seq(200, 1'b1, rh, wr, nz, mc, dn);
        total++; if (dn !== 1'b1 || rh != 4 || wr != 16) begin bad++; $display("FAIL en_seq got=%0b/%0d/%0d exp=1/4/16", dn, rh, wr); end
        total++; if (core_reset !== 1'b0 || fsm_state !== ST_RUN) begin bad++; $display("FAIL en_final got=%0b/%0d exp=0/RUN", core_reset, fsm_state); end
    endtask

    initial begin
        test_reset;
        test_tone_pass;
        test_metronome;
        test_tuner;
        test_timeout;
        test_retrig;
        test_enable_switch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
